// File: rtl/noc_pkg.sv
// Shared definitions for the 2x2 mesh NoC: node indexing, flit layout, scheduler states.
package noc_pkg;
  localparam int NOC_NODES = 4;
  localparam int FLIT_W    = 16;

  typedef logic [1:0] node_idx_t;

  localparam int FLIT_CNT_MSB = 15;
  localparam int FLIT_CNT_LSB = 5;
  localparam int FLIT_SRC_MSB = 4;
  localparam int FLIT_SRC_LSB = 3;
  localparam int FLIT_DST_MSB = 2;
  localparam int FLIT_DST_LSB = 1;
  localparam int FLIT_VLD_BIT = 0;

  typedef struct packed {
    logic [10:0] count;
    node_idx_t   src;
    node_idx_t   dst;
    logic        valid;
  } flit_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;
endpackage

// File: rtl/noc_inject_sched_rr_pick4.sv
// Round-robin pick of the first eligible node after rr; purely combinational, no backpressure.
module rr_pick4
  import noc_pkg::*;
(
  input  logic [3:0] elig,
  input  node_idx_t  rr,
  output logic       found,
  output node_idx_t  idx
);
  node_idx_t cand;

  // Walk rr+4 down to rr+1 so the nearest eligible successor wins.
  always_comb begin
    found = 1'b0;
    idx   = rr;
    cand  = rr;
    for (int k = 4; k >= 1; k--) begin
      cand = rr + node_idx_t'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/noc_inject_sched.sv
// Time-division round-robin injection scheduler; enable is registered, first grant one cycle after start.
// Skips masked or full nodes; a grant held against full for STALL_LIMIT cycles is revoked and flagged.
module noc_inject_sched
  import noc_pkg::*;
#(
  parameter int SLOT_W       = 4,
  parameter int CNT_W        = 16,
  parameter int STALL_LIMIT  = 64,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [3:0]             node_mask,
  input  logic [SLOT_W-1:0]      slot_len,
  input  logic [3:0]             full,
  input  logic [3:0]             almost_full,
  input  logic [3:0]             write,
  output logic [3:0]             enable,
  output logic                   busy,
  output logic                   done,
  output logic                   stall_err,
  output logic [4*CNT_W-1:0]     sent_count
);
  localparam int SC_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  localparam int DC_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  sched_state_e      state_q, state_d;
  node_idx_t         rr_q, rr_d, pick_idx;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SC_W-1:0]   stall_q, stall_d;
  logic [DC_W-1:0]   drain_q, drain_d;
  logic [3:0]        enable_d;
  logic              done_d, stall_err_d, clr_cnt, pick_found, granted, stall_hit, arb;
  logic              af_unused;

  // almost_full is status for external counters; the scheduler does not act on it.
  assign af_unused = ^almost_full;
  assign granted   = |enable;
  assign busy      = (state_q != IDLE);

  rr_pick4 u_pick (
    .elig  (node_mask & ~full),
    .rr    (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    slot_d      = slot_q;
    drain_d     = drain_q;
    enable_d    = enable;
    done_d      = 1'b0;
    stall_err_d = stall_err;
    clr_cnt     = 1'b0;
    stall_hit   = 1'b0;
    arb         = 1'b0;
    case (state_q)
      IDLE: begin
        enable_d = 4'b0000;
        if (start) begin
          state_d     = RUN;
          stall_err_d = 1'b0;
          clr_cnt     = 1'b1;
        end
      end
      RUN: begin
        stall_hit = granted && full[rr_q] && (stall_q == SC_W'(STALL_LIMIT - 1));
        if (stop) begin
          state_d  = DRAIN;
          enable_d = 4'b0000;
          drain_d  = '0;
        end else if (granted && (!node_mask[rr_q] || stall_hit)) begin
          enable_d = 4'b0000;
          if (stall_hit) stall_err_d = 1'b1;
        end else if (granted && (slot_q != '0)) begin
          slot_d = slot_q - 1'b1;
        end else begin
          arb = 1'b1;
        end
        if (arb) begin
          if (pick_found) begin
            enable_d = 4'b0001 << pick_idx;
            rr_d     = pick_idx;
            slot_d   = (slot_len == '0) ? '0 : slot_len - 1'b1;
          end else begin
            enable_d = 4'b0000;
          end
        end
      end
      DRAIN: begin
        enable_d = 4'b0000;
        if (drain_q == DC_W'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 4'b0000;
      end
    endcase
    // Stall run survives only while the same grant keeps seeing full.
    if ((state_q == RUN) && !stop && granted && full[rr_q] && !stall_hit && (enable_d == enable))
      stall_d = stall_q + 1'b1;
    else
      stall_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= 2'd3;
      slot_q    <= '0;
      stall_q   <= '0;
      drain_q   <= '0;
      enable    <= 4'b0000;
      done      <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      slot_q    <= slot_d;
      stall_q   <= stall_d;
      drain_q   <= drain_d;
      enable    <= enable_d;
      done      <= done_d;
      stall_err <= stall_err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_count <= '0;
    end else if (clr_cnt) begin
      sent_count <= '0;
    end else begin
      for (int i = 0; i < NOC_NODES; i++) begin
        if (busy && write[i] && (sent_count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          sent_count[i*CNT_W +: CNT_W] <= sent_count[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_noc_inject_sched.sv
// Bench for noc_inject_sched: directed vector table, corner sequences, random run against a reference model.
module tb_noc_inject_sched;
  localparam int SLOT_W       = 4;
  localparam int CNT_W        = 4;
  localparam int STALL_LIMIT  = 10;
  localparam int DRAIN_CYCLES = 8;
  localparam int MAX_CNT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, start, stop;
  logic [3:0] node_mask, full, almost_full, write;
  logic [SLOT_W-1:0] slot_len;
  logic [3:0] enable;
  logic busy, done, stall_err;
  logic [4*CNT_W-1:0] sent_count;

  int checks = 0;
  int errors = 0;

  noc_inject_sched #(
    .SLOT_W(SLOT_W), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .node_mask(node_mask),
    .slot_len(slot_len), .full(full), .almost_full(almost_full), .write(write),
    .enable(enable), .busy(busy), .done(done), .stall_err(stall_err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle / 1 run / 2 drain, grant -1 when nothing enabled.
  int m_phase, m_grant, m_last, m_left, m_fullrun, m_drain;
  bit m_done, m_err;
  int m_cnt[4];

  task automatic model_reset();
    m_phase = 0; m_grant = -1; m_last = 3; m_left = 0; m_fullrun = 0; m_drain = 0;
    m_done = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    int prev, j;
    bit stalled, hit;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_phase != 0)
      for (int i = 0; i < 4; i++) if (write[i] && m_cnt[i] < MAX_CNT) m_cnt[i]++;
    m_done = 0;
    case (m_phase)
      0: if (start) begin
        m_phase = 1; m_err = 0; m_grant = -1; m_fullrun = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end
      1: if (stop) begin
        m_phase = 2; m_grant = -1; m_drain = 0; m_fullrun = 0;
      end else begin
        prev = m_grant;
        stalled = (m_grant >= 0) && full[m_grant];
        m_fullrun = stalled ? m_fullrun + 1 : 0;
        hit = stalled && (m_fullrun == STALL_LIMIT);
        if (m_grant >= 0 && (!node_mask[m_grant] || hit)) begin
          if (hit) m_err = 1;
          m_grant = -1;
        end else if (m_grant >= 0 && m_left > 0) begin
          m_left--;
        end else begin
          m_grant = -1;
          for (int k = 1; k <= 4; k++) begin
            j = (m_last + k) % 4;
            if (node_mask[j] && !full[j]) begin
              m_grant = j; m_last = j;
              m_left = (slot_len == 0) ? 0 : int'(slot_len) - 1;
              break;
            end
          end
        end
        if (m_grant != prev) m_fullrun = 0;
      end
      default: begin
        m_drain++;
        if (m_drain == DRAIN_CYCLES) begin
          m_phase = 0; m_done = 1;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_en;
    exp_en = (m_grant >= 0) ? (4'b0001 << m_grant) : 4'b0000;
    chk("model_enable", 32'(enable), 32'(exp_en));
    chk("model_busy", 32'(busy), 32'(m_phase != 0));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_stall_err", 32'(stall_err), 32'(m_err));
    for (int i = 0; i < 4; i++)
      chk("model_sent_count", 32'(sent_count[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
    chk("enable_onehot0", 32'($countones(enable) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic       st, sp;
    logic [3:0] mask, slen, fl;
    logic [3:0] exp_en;
    logic       exp_busy, exp_done;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic st, sp, input logic [3:0] mask, slen, fl, en,
                     input logic bz, dn);
    vec_t v;
    v.st = st; v.sp = sp; v.mask = mask; v.slen = slen; v.fl = fl;
    v.exp_en = en; v.exp_busy = bz; v.exp_done = dn;
    vecs.push_back(v);
  endtask

  initial begin
    int k, done_at, done_cnt;
    logic full_mode;
    reset = 1'b0; start = 0; stop = 0; node_mask = 4'hF; slot_len = 4'd1;
    full = 0; almost_full = 0; write = 0;
    model_reset();

    // Rotation, masked slots, full-skip, then stop and drain.
    add(1,0,4'hF,1,4'h0,4'b0000,1,0);
    add(0,0,4'hF,1,4'h0,4'b0001,1,0); add(0,0,4'hF,1,4'h0,4'b0010,1,0);
    add(0,0,4'hF,1,4'h0,4'b0100,1,0); add(0,0,4'hF,1,4'h0,4'b1000,1,0);
    add(0,0,4'hF,1,4'h0,4'b0001,1,0);
    add(0,0,4'h5,3,4'h0,4'b0100,1,0); add(0,0,4'h5,3,4'h0,4'b0100,1,0);
    add(0,0,4'h5,3,4'h0,4'b0100,1,0); add(0,0,4'h5,3,4'h0,4'b0001,1,0);
    add(0,0,4'h5,3,4'h0,4'b0001,1,0); add(0,0,4'h5,3,4'h0,4'b0001,1,0);
    add(0,0,4'h5,3,4'h0,4'b0100,1,0);
    add(0,0,4'hF,1,4'h2,4'b0100,1,0); add(0,0,4'hF,1,4'h2,4'b0100,1,0);
    add(0,0,4'hF,1,4'h2,4'b1000,1,0); add(0,0,4'hF,1,4'h2,4'b0001,1,0);
    add(0,0,4'hF,1,4'h2,4'b0100,1,0); add(0,0,4'hF,1,4'h2,4'b1000,1,0);
    add(0,0,4'hF,1,4'h2,4'b0001,1,0);
    add(0,0,4'hF,1,4'h0,4'b0010,1,0);
    add(0,1,4'hF,1,4'h0,4'b0000,1,0);
    for (int i = 0; i < DRAIN_CYCLES - 1; i++) add(0,0,4'hF,1,4'h0,4'b0000,1,0);
    add(0,0,4'hF,1,4'h0,4'b0000,0,1);
    add(0,0,4'hF,1,4'h0,4'b0000,0,0);

    tick();
    chk("reset_enable", 32'(enable), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_counts", 32'(sent_count), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stop = vecs[i].sp; node_mask = vecs[i].mask;
      slot_len = vecs[i].slen; full = vecs[i].fl;
      tick();
      chk("vec_enable", 32'(enable), 32'(vecs[i].exp_en));
      chk("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
      chk("vec_done", 32'(done), 32'(vecs[i].exp_done));
    end
    start = 0; stop = 0;

    // Stall: node 0 held against full until the limit revokes the grant.
    node_mask = 4'b0001; slot_len = 4'd15; start = 1; tick(); start = 0;
    tick(); chk("stall_first_grant", 32'(enable), 32'b0001);
    full = 4'b0001; node_mask = 4'b0011;
    for (int i = 1; i < STALL_LIMIT; i++) begin
      tick();
      chk("stall_hold_enable", 32'(enable), 32'b0001);
      chk("stall_not_yet", 32'(stall_err), 0);
    end
    tick();
    chk("stall_err_set", 32'(stall_err), 1);
    chk("stall_revoked", 32'(enable), 0);
    tick(); chk("stall_next_node", 32'(enable), 32'b0010);
    full = 0; stop = 1; tick(); stop = 0;
    for (int i = 0; i < DRAIN_CYCLES; i++) tick();
    chk("stall_err_sticky", 32'(stall_err), 1);
    start = 1; tick(); start = 0;
    chk("stall_err_cleared", 32'(stall_err), 0);

    // Counting through RUN and DRAIN, including saturation.
    node_mask = 4'b0100; slot_len = 4'd1;
    write = 4'b0110; for (int i = 0; i < 10; i++) tick();
    write = 4'b0010; for (int i = 0; i < 10; i++) tick();
    write = 0; stop = 1; tick(); stop = 0;
    chk("drain_enable_off", 32'(enable), 0);
    done_at = -1; done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      write = (i <= 2) ? 4'b0100 : 4'b0000;
      tick();
      if (done) begin done_cnt++; if (done_at < 0) done_at = i; end
    end
    chk("done_pulse_count", 32'(done_cnt), 1);
    chk("done_timing", 32'(done_at), DRAIN_CYCLES);
    chk("sent_count2", 32'(sent_count[2*CNT_W +: CNT_W]), 12);
    chk("sent_count1_sat", 32'(sent_count[1*CNT_W +: CNT_W]), MAX_CNT);
    chk("busy_after_done", 32'(busy), 0);

    // Async reset mid-slot.
    slot_len = 4'd15; start = 1; tick(); start = 0; write = 4'b0100;
    k = 0;
    while (enable != 4'b0100 && k < 5) begin tick(); k++; end
    chk("rst_grant_seen", 32'(enable), 32'b0100);
    tick();
    #3 reset = 1'b0; model_reset();
    #1;
    chk("async_rst_enable", 32'(enable), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_counts", 32'(sent_count), 0);
    write = 0; tick(); tick();
    reset = 1'b1; node_mask = 4'hF; slot_len = 4'd1;
    start = 1; tick(); start = 0; tick();
    chk("post_rst_first_grant", 32'(enable), 32'b0001);

    // Random traffic against the reference model.
    full_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) node_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) slot_len = SLOT_W'($urandom);
      if ($urandom_range(0, 99) < 3) full_mode = ~full_mode;
      full = full_mode ? 4'($urandom | $urandom) : 4'($urandom & $urandom & $urandom);
      almost_full = 4'($urandom);
      write = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_inject_sched.md
Name: noc_inject_sched

Overview:
- Injection scheduler for the 2x2 mesh `noc` (16-bit flits, four local ports 0..3).
- Drives the per-node `enable` inputs of the traffic sources with a time-division, round-robin slot schedule.
  - Skips nodes that are masked off or whose ingress FIFO is full.
  - Counts injected flits per node.
  - Flags injection stalls.
- Sits between run-control logic and the four source `cpu` instances.
- Replaces hand-written enable sequencing.

Parameters:
- SLOT_W, 4, width of slot_len.
- CNT_W, 16, width of each per-node sent counter.
- STALL_LIMIT, 64, consecutive cycles a granted node may see full=1 before stall_err.
- DRAIN_CYCLES, 8, idle cycles after stop before done.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins scheduling (ignored unless IDLE).
- stop  in  1  one-cycle pulse; ends scheduling (ignored unless RUN).
- node_mask  in  4  bit i=1 allows node i to be granted; sampled every cycle.
- slot_len  in  SLOT_W  cycles per grant slot; 0 treated as 1; sampled at slot start.
- full  in  4  ingress FIFO full per node.
- almost_full  in  4  ingress FIFO almost-full per node (status only, routed to counters).
- write  in  4  per-node write strobe from sources (counted).
- enable  out  4  one-hot or zero grant to sources; registered.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on DRAIN->IDLE.
- stall_err  out  1  sticky; set on stall, cleared by start.
- sent_count  out  4*CNT_W  node i count in bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset=0, async):
  - Outputs: enable=0, busy=0, done=0, stall_err=0, all sent_count=0.
  - Internal: state=IDLE, rr pointer=3 (so node 0 is first candidate), slot counter=0, stall counter=0.
- FSM states:
  - IDLE -> RUN on start.
    - Clears sent_count and stall_err.
    - Rotation and slot counter are *not* reset by start; rr pointer persists from any previous run (reset to 3 only by reset).
  - RUN -> DRAIN on stop (stop has priority over slot advance in the same cycle).
    - enable goes to 0 on the next edge.
  - DRAIN:
    - Counts DRAIN_CYCLES cycles with enable=0.
    - Then -> IDLE, done=1 for exactly one cycle.
  - start during RUN/DRAIN is ignored; stop during IDLE/DRAIN is ignored.
- Slot arbitration (RUN):
  - At slot start, choose the first node j in order rr+1, rr+2, rr+3, rr+4 (mod 4) with node_mask[j]=1 and full[j]=0.
  - If found:
    - Registered effect: enable=onehot(j), rr<=j, slot counter loads max(slot_len,1)-1.
  - If none eligible: enable=0 and re-arbitrate the following cycle; rr unchanged.
- Slot hold:
  - While slot counter>0, decrement; enable holds.
  - When it reaches 0, the next cycle is a new slot start.
  - Latency: first enable is asserted 1 cycle after start is sampled (the start edge moves IDLE->RUN, the next edge performs the first arbitration).
- Mid-slot deassertions:
  - If node_mask[j] drops mid-slot: end slot immediately; re-arbitrate next cycle, j excluded.
  - full[j] rising mid-slot does not end the slot (sources self-throttle).
- Stall detection:
  - Stall counter increments each cycle enable[j]=1 and full[j]=1.
  - Clears when full[j]=0 or the grant changes.
  - Reaching STALL_LIMIT sets stall_err and forces slot end.
- Counting:
  - sent_count[i] increments on each cycle write[i]=1 while busy=1, saturating at all-ones.
  - A write in DRAIN is counted (in-flight flits).
- Invariant: enable is never multi-hot.

Decomposition:
- Shared package `noc_pkg`:
  - NOC_NODES=4, FLIT_W=16.
  - Node index typedef (2 bits).
  - Flit field offsets {count[15:5], src[4:3], dst[2:1], valid[0]}.
  - Scheduler state enum {IDLE, RUN, DRAIN}.
- One sub-module: `rr_pick4`.
  - Combinational.
  - Inputs: eligibility vector, rr pointer.
  - Outputs: found, index.
- Counters and FSM stay in the top module.

Test Plan:
1. Reset release, node_mask=4'b1111, slot_len=1, full=0, start -> enable sequence 0001,0010,0100,1000,0001 on consecutive cycles, first grant 1 cycle after the start edge.
2. node_mask=4'b0101, slot_len=3 -> enable=0001 for 3 cycles, 0100 for 3 cycles, repeating; nodes 1,3 never enabled.
3. full=4'b0010 held, mask=1111, slot_len=1 -> rotation 0001,0100,1000, node 1 skipped. Release full -> node 1 granted in its next turn.
4. Granted node 0 with full[0] forced high 64 cycles, STALL_LIMIT=64 -> stall_err=1 at cycle 64, grant moves to node 1. Next start clears stall_err.
5. write[2] pulsed 10 times during RUN, stop, 2 more writes in DRAIN -> sent_count[2]=12. done pulses once 8 cycles after enable drops; busy low thereafter.
6. reset asserted mid-slot with enable=0100 -> enable=0, busy=0, counts=0 immediately (async). After release + start, first grant=0001.
